fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage directly upstream of the instruction ROM: owns the program counter, drives `PC` into the ROM, and absorbs the ROM's one-cycle registered read latency. Presents instruction, instruction address and a valid flag to decode through an IF/ID register, with a one-entry skid for stalls. Handles taken-branch redirects with wrong-path squash, and halts fetch past the end of program memory.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `IMEM_WORDS`, 7: number of valid ROM words; word index `PC>>2 >= IMEM_WORDS` is out of range.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PC`  out  32  fetch address to ROM; ROM samples it each edge; ROM `inst` valid the following cycle.
- `rom_inst`  in  32  ROM `inst` output.
- `stall`  in  1  decode not accepting; IF/ID contents must hold.
- `branch_taken`  in  1  redirect request, one cycle pulse.
- `branch_pc`  in  32  address of the branch instruction.
- `branch_imm24`  in  24  branch immediate field, bits [23:0].
- `inst_out`  out  32  IF/ID instruction.
- `inst_pc`  out  32  address of `inst_out`.
- `inst_valid`  out  1  `inst_out` is a real, non-squashed instruction.
- `halted`  out  1  PC is out of range; no fetch being issued.

## Operation
- Internal state:
  - `PC` register.
  - `req_valid_q`/`req_pc_q`: whether the ROM sampled an in-range address at the last edge, and which one.
  - Skid entry: valid, inst, pc.
  - IF/ID register: `inst_out`, `inst_pc`, `inst_valid`.
- ROM word is usable this cycle iff `req_valid_q` and no squash is pending; its address is `req_pc_q`.
- Branch target = `branch_pc + 8 + (sign_extend(branch_imm24) << 2)`, 32-bit, wrap-around modulo 2^32.
- Priority each cycle:
  - `rst`: `PC <= RESET_PC`; IF/ID and skid clear; `req_valid_q <= 0`.
  - `branch_taken`: overrides `stall`.
    - `PC <= target`; `inst_valid <= 0`.
    - Skid cleared; the in-flight ROM word is marked squashed.
  - `stall` with skid empty:
    - PC, IF/ID hold.
    - The usable ROM word is captured into the skid.
  - `stall` with skid full: everything holds; ROM word discarded. It is a refetch of the held PC and reappears.
  - No stall, skid full:
    - IF/ID <= skid; skid empties; `PC <= PC+4`.
    - Current ROM word discarded; it is the refetch of the held PC, repeated next cycle.
  - No stall, skid empty:
    - IF/ID <= usable ROM word; `inst_valid` = usable.
    - `PC <= PC+4` if in range.
- Out of range:
  - When `PC>>2 >= IMEM_WORDS`: PC holds, `req_valid_q <= 0`, `halted = 1`.
  - Already-fetched words still drain to IF/ID.
  - A `branch_taken` to an in-range target leaves halt.
- `halted` is combinational from `PC` and `IMEM_WORDS`.

## Timing
- Reset values:
  - `PC = RESET_PC`.
  - `inst_out = 0`, `inst_pc = 0`, `inst_valid = 0`.
  - `halted = (RESET_PC>>2 >= IMEM_WORDS)`.
- Fetch latency: PC = A during cycle n → ROM word during n+1 → `inst_valid` with `inst_pc = A` during n+2.
- First valid instruction: cycle 2 after the first cycle with `rst` low.
- Sustained throughput: one instruction per cycle, no bubbles when unstalled.
- Branch: `branch_taken` in cycle n → PC = target in n+1 → `inst_valid` low in n+1 and n+2 → target instruction valid in n+3.
- Stall: asserted in cycle n → IF/ID unchanged from n through the last stalled cycle.
  - The instruction after the held one appears the first cycle after `stall` falls.
  - No instruction is lost or duplicated.
- Reset mid-stall or mid-branch: reset wins and clears skid and squash state.

## Structure
- Shared package `cpu_pkg`:
  - `inst_t` (32-bit) typedef.
  - `WORD_BYTES = 4`.
  - `PC_PIPE_OFFSET = 8`.
  - `branch_target(pc, imm24)` function, shared with execute.
- Sub-module `fetch_skid`: one-entry buffer with inst and pc payload, plus load/drain/clear controls.

## Test plan
- Reset released, no stall/branch, ROM program 0xE3A02005, 0xE3A03008, 0xE0824003, … → `inst_valid` from cycle 2; `inst_pc` = 0,4,8,…,24, one per cycle, then `halted=1`, valid low after 24.
- `stall` high for 3 cycles while `inst_pc=8` → `inst_out=0xE0824003` held 3 cycles, then `inst_pc` 12,16 consecutively, no gap or repeat.
- `branch_taken` with `branch_pc=16`, `imm24=24'hFFFFFD` → target 12; two invalid cycles, then `inst_pc=12`.
- `branch_taken` and `stall` asserted together → branch taken, stall ignored that cycle, skid cleared.
- `branch_pc=32'hFFFF_FFF8`, `imm24=0` → target wraps to 0; fetch resumes at 0, `halted` low.
- `rst` asserted during a stall with skid full → next cycle all outputs at reset values; restart from `RESET_PC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and helpers used by fetch and execute.
package cpu_pkg;

    typedef logic [31:0] inst_t;

    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned PC_PIPE_OFFSET = 8;

    // PC reads two words ahead of the branch, hence the fixed offset.
    function automatic logic [31:0] branch_target(
        input logic [31:0] pc,
        input logic [23:0] imm24
    );
        return pc + 32'(PC_PIPE_OFFSET)
            + {{6{imm24[23]}}, imm24, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, redirect, and IF/ID outputs.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic [31:0] PC;
    inst_t       rom_inst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic [23:0] branch_imm24;
    inst_t       inst_out;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        halted;

    modport master (
        output PC, inst_out, inst_pc, inst_valid, halted,
        input  rom_inst, stall, branch_taken,
        input  branch_pc, branch_imm24
    );

    modport slave (
        input  PC, inst_out, inst_pc, inst_valid, halted,
        output rom_inst, stall, branch_taken,
        output branch_pc, branch_imm24
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction and its address.
module fetch_skid
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  inst_t       inst_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output inst_t       inst_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    inst_t       inst_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, ROM latency absorption, IF/ID with skid,
// branch redirect with wrong-path squash, halt past end of ROM.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 7
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    logic [31:0] pc_q, pc_d;
    logic        req_valid_q;
    logic [31:0] req_pc_q;
    logic        squash_q;
    inst_t       inst_q, inst_d;
    logic [31:0] ipc_q, ipc_d;
    logic        ival_q, ival_d;

    logic        skid_v;
    inst_t       skid_inst;
    logic [31:0] skid_pc;
    logic        skid_load, skid_drain, skid_clear;

    logic        in_range, usable;
    logic [31:0] pc_next;
    logic        br_c, cap_c, full_c, drain_c, run_c;

    assign in_range = (pc_q >> 2) < 32'(IMEM_WORDS);
    assign usable   = req_valid_q && !squash_q;
    assign pc_next  = in_range ? pc_q + 32'(WORD_BYTES) : pc_q;

    assign br_c    = bus.branch_taken;
    assign cap_c   = !br_c && bus.stall && !skid_v;
    assign full_c  = !br_c && bus.stall && skid_v;
    assign drain_c = !br_c && !bus.stall && skid_v;
    assign run_c   = !br_c && !bus.stall && !skid_v;

    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        ipc_d      = ipc_q;
        ival_d     = ival_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        unique case (1'b1)
            br_c: begin
                pc_d       = branch_target(bus.branch_pc, bus.branch_imm24);
                ival_d     = 1'b0;
                skid_clear = 1'b1;
            end
            cap_c: begin
                skid_load = usable;
            end
            // ROM word here is a refetch of the held PC; drop it.
            full_c: begin
            end
            drain_c: begin
                inst_d     = skid_inst;
                ipc_d      = skid_pc;
                ival_d     = 1'b1;
                skid_drain = 1'b1;
                pc_d       = pc_next;
            end
            run_c: begin
                ival_d = usable;
                if (usable) begin
                    inst_d = bus.rom_inst;
                    ipc_d  = req_pc_q;
                end
                pc_d = pc_next;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
            squash_q    <= 1'b0;
            inst_q      <= '0;
            ipc_q       <= '0;
            ival_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_valid_q <= in_range;
            req_pc_q    <= pc_q;
            squash_q    <= bus.branch_taken;
            inst_q      <= inst_d;
            ipc_q       <= ipc_d;
            ival_q      <= ival_d;
        end
    end

    fetch_skid u_skid (
        .clk    (clk),
        .rst    (rst),
        .load_i (skid_load),
        .drain_i(skid_drain),
        .clear_i(skid_clear),
        .inst_i (bus.rom_inst),
        .pc_i   (req_pc_q),
        .valid_o(skid_v),
        .inst_o (skid_inst),
        .pc_o   (skid_pc)
    );

    assign bus.PC         = pc_q;
    assign bus.inst_out   = inst_q;
    assign bus.inst_pc    = ipc_q;
    assign bus.inst_valid = ival_q;
    assign bus.halted     = !in_range;

endmodule
